// File: rtl/wb_master_engine.sv
// wb_master_engine: Wishbone classic-cycle master for the ethmac environment.
// Commands are queued in a FIFO. Each command is issued as a single Wishbone
// cycle, and each cycle returns exactly one response.
//
// Ports
//   wb_clk_i, wb_rst_i          clock; synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_we/adr/dat/sel          command payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat/rsp_err/rsp_tout    response payload
//   wb_adr_o..wb_stb_o          master side of the Wishbone bus
//   wb_dat_i/ack_i/err_i        slave returns
//   busy                        high while a command is queued, in flight or unconsumed
module wb_master_engine #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned SW         = DW / 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  input  logic [SW-1:0] cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_err,
  output logic          rsp_tout,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CYCLE, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } cmd_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q;
  state_t        state_q;

  logic push, pop, launch, nonempty;
  cmd_t head;

  assign nonempty  = (count_q != '0);
  assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // A new cycle may start from IDLE or on the edge that consumes the response.
  assign launch    = nonempty && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
  assign pop       = launch;
  assign head      = mem_q[rd_ptr_q];
  assign busy      = nonempty || (state_q != IDLE);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wr_ptr_q] <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      rsp_tout  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);

      unique case (state_q)
        CYCLE: begin
          if (wb_err_i || wb_ack_i || timer_q == TW'(TIMEOUT - 1)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= wb_err_i;
            rsp_tout  <= !wb_err_i && !wb_ack_i;
            rsp_dat   <= (!wb_err_i && wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
            state_q   <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            rsp_tout  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: ;
      endcase

      // Launch is placed after the case so its state update overrides the
      // RESP->IDLE fallback on back-to-back commands.
      if (launch) begin
        wb_adr_o <= head.adr;
        wb_dat_o <= head.dat;
        wb_sel_o <= head.sel;
        wb_we_o  <= head.we;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        timer_q  <= '0;
        state_q  <= CYCLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_engine.sv
module tb_wb_master_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_tout;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, busy;

  logic        man_ack = 1'b0, man_err = 1'b0, auto_ack = 1'b0, dat_from_adr = 1'b0;
  logic [31:0] slv_dat = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign wb_ack_i = man_ack | (auto_ack & wb_stb_o);
  assign wb_err_i = man_err;
  assign wb_dat_i = dat_from_adr ? (wb_adr_o ^ 32'hA500_0000) : slv_dat;

  wb_master_engine #(.AW(32), .DW(32), .SW(4), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_tout(rsp_tout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy)
  );

  // mode: 0 = silent slave, 1 = ack, 2 = err, 3 = ack and err together
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_n;
    logic [1:0]  mode;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_tout;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int unstable;
    slv_dat = v.rdata;
    push_cmd(v.we, v.adr, v.dat, v.sel);
    chk($sformatf("v%0d cyc_latency", idx), 64'(wb_cyc_o), 64'(0));
    tick();
    chk($sformatf("v%0d cyc_up", idx), 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'({2'b11, v.we}));
    chk($sformatf("v%0d adr", idx), 64'(wb_adr_o), 64'(v.adr));
    chk($sformatf("v%0d busy", idx), 64'(busy), 64'(1));
    k = 0;
    unstable = 0;
    while (wb_cyc_o && k < 50) begin
      k++;
      if (wb_adr_o !== v.adr || wb_dat_o !== v.dat || wb_sel_o !== v.sel ||
          wb_we_o !== v.we || wb_stb_o !== 1'b1)
        unstable++;
      if (k == v.wait_n + 1) begin
        man_ack = v.mode[0];
        man_err = v.mode[1];
      end
      tick();
      man_ack = 1'b0;
      man_err = 1'b0;
    end
    chk($sformatf("v%0d unstable", idx), 64'(unstable), 64'(0));
    chk($sformatf("v%0d stb_cycles", idx), 64'(k), 64'(v.exp_cyc));
    chk($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'(1));
    chk($sformatf("v%0d rsp_dat", idx), 64'(rsp_dat), 64'(v.exp_dat));
    chk($sformatf("v%0d err_tout", idx), 64'({rsp_err, rsp_tout}), 64'({v.exp_err, v.exp_tout}));
    chk($sformatf("v%0d bus_idle", idx), 64'({wb_adr_o, wb_we_o, wb_stb_o}), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d consumed", idx), 64'({rsp_valid, busy}), 64'(0));
  endtask

  initial begin
    vecs[0] = '{we: 1'b1, adr: 32'h40,  dat: 32'hA5A5_0001, sel: 4'hF, wait_n: 1, mode: 2'd1,
                rdata: 32'hFFFF_FFFF, exp_dat: 32'h0, exp_err: 1'b0, exp_tout: 1'b0, exp_cyc: 2};
    vecs[1] = '{we: 1'b0, adr: 32'h400, dat: 32'h0, sel: 4'hF, wait_n: 3, mode: 2'd1,
                rdata: 32'h1234_5678, exp_dat: 32'h1234_5678, exp_err: 1'b0, exp_tout: 1'b0, exp_cyc: 4};
    vecs[2] = '{we: 1'b0, adr: 32'h44,  dat: 32'h0, sel: 4'hF, wait_n: 0, mode: 2'd0,
                rdata: 32'h7777_7777, exp_dat: 32'h0, exp_err: 1'b0, exp_tout: 1'b1, exp_cyc: 8};
    vecs[3] = '{we: 1'b0, adr: 32'h48,  dat: 32'h0, sel: 4'h3, wait_n: 0, mode: 2'd1,
                rdata: 32'h0BAD_BEEF, exp_dat: 32'h0BAD_BEEF, exp_err: 1'b0, exp_tout: 1'b0, exp_cyc: 1};
    vecs[4] = '{we: 1'b0, adr: 32'h4C,  dat: 32'h0, sel: 4'hF, wait_n: 2, mode: 2'd2,
                rdata: 32'h0000_0055, exp_dat: 32'h0, exp_err: 1'b1, exp_tout: 1'b0, exp_cyc: 3};
    vecs[5] = '{we: 1'b1, adr: 32'h50,  dat: 32'h0000_0001, sel: 4'h1, wait_n: 0, mode: 2'd3,
                rdata: 32'h9999_9999, exp_dat: 32'h0, exp_err: 1'b1, exp_tout: 1'b0, exp_cyc: 1};

    // reset state
    tick();
    tick();
    chk("reset_outputs", 64'({rsp_valid, rsp_err, rsp_tout, wb_cyc_o, wb_stb_o, wb_we_o, busy}), 64'(0));
    chk("reset_bus", 64'({wb_adr_o, wb_dat_o}), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], i);

    // ack+err together under backpressure, queued write behind it
    begin
      int bad;
      rsp_ready = 1'b0;
      slv_dat = 32'hCAFE_F00D;
      man_ack = 1'b1;
      man_err = 1'b1;
      push_cmd(1'b0, 32'h200, 32'h0, 4'hF);
      push_cmd(1'b1, 32'h204, 32'h1111_2222, 4'hF);
      chk("bp_cyc_up", 64'(wb_cyc_o), 64'(1));
      tick();
      chk("bp_rsp", 64'({wb_cyc_o, rsp_valid, rsp_err, rsp_tout}), 64'(4'b0110));
      chk("bp_rsp_dat", 64'(rsp_dat), 64'(0));
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || wb_cyc_o !== 1'b0)
          bad++;
      end
      chk("bp_hold", 64'(bad), 64'(0));
      man_ack = 1'b0;
      man_err = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_next_launch", 64'({rsp_valid, wb_cyc_o, wb_we_o}), 64'(3'b011));
      chk("bp_next_adr", 64'(wb_adr_o), 64'(32'h204));
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("bp_next_rsp", 64'({rsp_valid, rsp_err, rsp_tout}), 64'(3'b100));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_drained", 64'({rsp_valid, busy}), 64'(0));
      // stray slave strobes in IDLE
      man_ack = 1'b1;
      man_err = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || busy !== 1'b0)
          bad++;
      end
      man_ack = 1'b0;
      man_err = 1'b0;
      chk("stray_ack_idle", 64'(bad), 64'(0));
    end

    // FIFO fill with stalled bus, then back-to-back drain in order
    begin
      logic [31:0] got [$];
      int edge_n, accept_edge, low_run, n;
      logic was_ready, prev_cyc;
      rsp_ready = 1'b1;
      dat_from_adr = 1'b1;
      auto_ack = 1'b0;
      cmd_valid = 1'b1;
      cmd_we = 1'b0;
      cmd_dat = '0;
      cmd_sel = 4'hF;
      for (int i = 0; i < 5; i++) begin
        cmd_adr = 32'h100 + 32'(i * 4);
        tick();
      end
      cmd_adr = 32'h114;
      chk("fill_full", 64'(cmd_ready), 64'(0));
      chk("fill_stalled", 64'({wb_cyc_o, busy}), 64'(2'b11));
      auto_ack = 1'b1;
      edge_n = 0;
      accept_edge = -1;
      low_run = 0;
      prev_cyc = wb_cyc_o;
      n = 0;
      while (got.size() < 6 && n < 60) begin
        n++;
        was_ready = cmd_ready;
        tick();
        edge_n++;
        if (cmd_valid && was_ready) begin
          accept_edge = edge_n;
          cmd_valid = 1'b0;
        end
        if (rsp_valid)
          got.push_back(rsp_dat);
        if (wb_cyc_o && !prev_cyc) begin
          chk($sformatf("gap_before_%0d", got.size()), 64'(low_run), 64'(1));
          low_run = 0;
        end else if (!wb_cyc_o) begin
          low_run++;
        end
        prev_cyc = wb_cyc_o;
      end
      cmd_valid = 1'b0;
      chk("fill_accept_edge", 64'(accept_edge), 64'(3));
      chk("fill_rsp_count", 64'(got.size()), 64'(6));
      for (int i = 0; i < got.size(); i++)
        chk($sformatf("fill_rsp%0d", i), 64'(got[i]), 64'((32'h100 + 32'(i * 4)) ^ 32'hA500_0000));
      tick();
      rsp_ready = 1'b0;
      auto_ack = 1'b0;
      dat_from_adr = 1'b0;
      chk("fill_done", 64'({busy, wb_cyc_o, rsp_valid}), 64'(0));
    end

    // reset mid-cycle with two commands queued
    begin
      int bad;
      push_cmd(1'b1, 32'h300, 32'h1, 4'hF);
      push_cmd(1'b0, 32'h304, 32'h0, 4'hF);
      push_cmd(1'b0, 32'h308, 32'h0, 4'hF);
      chk("rst_pre_cyc", 64'({wb_cyc_o, busy}), 64'(2'b11));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o}), 64'(0));
      chk("rst_flags", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
      bad = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || busy !== 1'b0)
          bad++;
      end
      rsp_ready = 1'b0;
      chk("rst_no_rsp", 64'(bad), 64'(0));
      run_vec(vecs[1], 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
